dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage (port A) and a loader/debug requester (port B), such as a test loader or a memory inspector.
- Memory model: 2048-word, byte address shifted right by 2, combinational read, write committed on the clock edge.
- Port A has priority. A bounded wait counter guarantees port B a slot; port A is stalled for that slot.
- Sits between the MEM stage, the hazard/stall logic and the data memory.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the pipeline MEM
//            stage (port A, priority) and a loader/debug requester (port B).
//            A bounded wait counter forces a B slot after MAX_WAIT refusals,
//            stalling A for that one cycle.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            a_req/a_we/a_addr/a_wdata -> a_rdata (comb), a_stall
//            b_req/b_we/b_addr/b_wdata -> b_ack (pulse), b_rdata, b_err
//            mem_address/mem_writedata/mem_memread/mem_memwrite -> memory
//            mem_readdata       <- memory (combinational read)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2048,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [0:0]       c_b_idle   = 1'b0;
    localparam logic [0:0]       c_b_ack    = 1'b1;
    localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);
    localparam logic [31:0]      c_depth    = 32'(DEPTH);

    logic [0:0]        r_bstate;
    logic [0:0]        w_bstate_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_b_err;

    logic w_b_elig;
    logic w_b_in_range;
    logic w_gnt_a;
    logic w_gnt_b;

    // Word index is the byte address shifted right by two.
    assign w_b_in_range = ({2'b00, b_addr[31:2]} < c_depth);

    // A new B request is only accepted from idle; holding b_req through the
    // ack cycle does not count as a second request.
    assign w_b_elig = b_req & (r_bstate == c_b_idle) & ~rst;
    assign w_gnt_b  = w_b_elig & (~a_req | (r_wait_cnt == c_max_wait));
    assign w_gnt_a  = a_req & ~w_gnt_b & ~rst;

    assign a_rdata = mem_readdata;
    assign a_stall = a_req & ~w_gnt_a;
    assign b_ack   = (r_bstate == c_b_ack);
    assign b_rdata = r_b_rdata;
    assign b_err   = r_b_err;

    // Memory drive; an out-of-range B access still gets its slot but issues
    // neither read nor write.
    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        mem_memread   = 1'b0;
        mem_memwrite  = 1'b0;
        if (w_gnt_a) begin
            mem_address   = a_addr;
            mem_writedata = a_wdata;
            mem_memwrite  = a_we;
            mem_memread   = ~a_we;
        end else if (w_gnt_b) begin
            mem_address   = b_addr;
            mem_writedata = b_wdata;
            if (w_b_in_range) begin
                mem_memwrite = b_we;
                mem_memread  = ~b_we;
            end
        end
    end

    // Next-state for the B handshake and the starvation counter.
    always_comb begin
        w_bstate_nxt = r_bstate;
        w_wait_nxt   = r_wait_cnt;
        if (w_gnt_b) begin
            w_bstate_nxt = c_b_ack;
        end else if (r_bstate == c_b_ack) begin
            w_bstate_nxt = c_b_idle;
        end
        if (w_gnt_b || !b_req || (r_bstate == c_b_ack)) begin
            w_wait_nxt = '0;
        end else if (w_b_elig && (r_wait_cnt != c_max_wait)) begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bstate   <= c_b_idle;
            r_wait_cnt <= '0;
        end else begin
            r_bstate   <= w_bstate_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // B result registers hold until the next B completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_rdata <= '0;
            r_b_err   <= 1'b0;
        end else if (w_gnt_b) begin
            r_b_rdata <= (!b_we && w_b_in_range) ? mem_readdata : '0;
            r_b_err   <= ~w_b_in_range;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural memory,
//            a reference model and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2048;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, a_we, b_req, b_we;
    logic [31:0]       a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              a_stall, b_ack, b_err;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic              mem_memread, mem_memwrite;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_readdata(mem_readdata)
    );

    // Data memory: combinational read, write on the clock edge.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    assign mem_readdata = (mem_address[31:13] == 19'd0) ? mem[mem_address[12:2]] : '0;

    always @(posedge clk) begin
        if (mem_memwrite && mem_address[31:13] == 19'd0)
            mem[mem_address[12:2]] <= mem_writedata;
    end

    // Reference model state
    int          m_refused;
    bit          m_ack;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_awin, m_bwin;

    // Observations of the last combinational phase
    logic        obs_stall, obs_memread, obs_memwrite;
    logic [31:0] obs_addr, obs_rdata;

    int checks = 0;
    int errors = 0;

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:13] == 19'd0;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_2000;
        return {19'd0, 11'($urandom_range(0, DEPTH - 1)), 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check combinational outputs, advance the model at the
    // edge, then check the registered B outputs just after it.
    task automatic cycle();
        logic [31:0] exp_addr, exp_wd;
        bit exp_rd, exp_wr, addr_known, prev_ack;
        #2;
        if (rst) begin
            m_bwin = 0;
            m_awin = 0;
        end else begin
            m_bwin = b_req && !m_ack && (!a_req || m_refused >= MAX_WAIT);
            m_awin = a_req && !m_bwin;
        end
        exp_addr = 0; exp_wd = 0; exp_rd = 0; exp_wr = 0; addr_known = 1;
        if (m_awin) begin
            exp_addr = a_addr; exp_wd = a_wdata; exp_wr = a_we; exp_rd = !a_we;
        end else if (m_bwin) begin
            if (in_rng(b_addr)) begin
                exp_addr = b_addr; exp_wd = b_wdata; exp_wr = b_we; exp_rd = !b_we;
            end else begin
                addr_known = 0;
            end
        end
        chk("a_stall", 32'(a_stall), 32'(a_req && !m_awin));
        chk("mem_memread", 32'(mem_memread), 32'(exp_rd));
        chk("mem_memwrite", 32'(mem_memwrite), 32'(exp_wr));
        if (addr_known) begin
            chk("mem_address", mem_address, exp_addr);
            chk("mem_writedata", mem_writedata, exp_wd);
            chk("a_rdata", a_rdata, in_rng(exp_addr) ? ref_mem[exp_addr[12:2]] : 32'h0);
        end
        obs_stall = a_stall; obs_memread = mem_memread; obs_memwrite = mem_memwrite;
        obs_addr = mem_address; obs_rdata = a_rdata;
        @(posedge clk);
        if (rst) begin
            m_refused = 0; m_ack = 0; m_rdata = 0; m_err = 0;
        end else begin
            prev_ack = m_ack;
            if (m_bwin) begin
                m_ack     = 1;
                m_err     = !in_rng(b_addr);
                m_rdata   = (!b_we && in_rng(b_addr)) ? ref_mem[b_addr[12:2]] : 32'h0;
                m_refused = 0;
                if (b_we && in_rng(b_addr)) ref_mem[b_addr[12:2]] = b_wdata;
            end else begin
                m_ack = 0;
                if (!b_req || prev_ack) m_refused = 0;
                else if (m_refused < MAX_WAIT) m_refused++;
            end
            if (m_awin && a_we && in_rng(a_addr)) ref_mem[a_addr[12:2]] = a_wdata;
        end
        #1;
        chk("b_ack", 32'(b_ack), 32'(m_ack));
        chk("b_rdata", b_rdata, m_rdata);
        chk("b_err", 32'(b_err), 32'(m_err));
    endtask

    initial begin
        int g, ack_c, n_gnt, n_ack, first_g, second_g;
        logic [31:0] snap;
        bit st [8];

        for (int i = 0; i < DEPTH; i++) begin
            snap = $urandom;
            mem[i] = snap;
            ref_mem[i] = snap;
        end
        m_refused = 0; m_ack = 0; m_rdata = 0; m_err = 0;
        rst = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        #1;

        // Reset state
        cycle(); cycle();
        chk("rst_b_ack", 32'(b_ack), 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_b_err", 32'(b_err), 32'h0);
        rst = 0;

        // Uncontended A read of word 500
        mem[500] = 32'h1234_5678; ref_mem[500] = 32'h1234_5678;
        a_req = 1; a_we = 0; a_addr = 32'h7D0;
        cycle();
        chk("a_read_addr", obs_addr, 32'h7D0);
        chk("a_read_memread", 32'(obs_memread), 32'h1);
        chk("a_read_rdata", obs_rdata, 32'h1234_5678);
        chk("a_read_stall", 32'(obs_stall), 32'h0);

        // Uncontended B write to word 501
        a_req = 0; b_req = 1; b_we = 1; b_addr = 32'h7D4; b_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("b_wr_memwrite", 32'(obs_memwrite), 32'h1);
        b_req = 0;
        chk("b_wr_ack", 32'(b_ack), 32'h1);
        chk("b_wr_err", 32'(b_err), 32'h0);
        chk("b_wr_mem501", mem[501], 32'hDEAD_BEEF);
        cycle();

        // Starvation bound under continuous A traffic
        a_req = 1; a_we = 0; a_addr = 32'h10;
        b_req = 1; b_we = 0; b_addr = 32'h100;
        g = -1; ack_c = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            st[k] = obs_stall;
            if (obs_stall && g < 0) g = k;
            if (b_ack && ack_c < 0) begin
                ack_c = k + 1;
                chk("starve_b_rdata", b_rdata, mem[64]);
                b_req = 0;
            end
        end
        chk("starve_grant_cycle", 32'(g), 32'd4);
        chk("starve_ack_cycle", 32'(ack_c), 32'd5);
        chk("starve_a_resumes", 32'(st[5]), 32'h0);
        a_req = 0;

        // Out-of-range B write
        snap = mem[0];
        b_req = 1; b_we = 1; b_addr = 32'h2000; b_wdata = 32'hCAFE_F00D;
        cycle();
        chk("oor_memwrite", 32'(obs_memwrite), 32'h0);
        b_req = 0;
        chk("oor_ack", 32'(b_ack), 32'h1);
        chk("oor_err", 32'(b_err), 32'h1);
        chk("oor_rdata", b_rdata, 32'h0);
        chk("oor_mem_unchanged", mem[0], snap);
        cycle();

        // B held high through ack
        b_req = 1; b_we = 0; b_addr = 32'h40;
        n_gnt = 0; n_ack = 0; first_g = -1; second_g = -1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_memread) begin
                n_gnt++;
                if (first_g < 0) first_g = k;
                else if (second_g < 0) second_g = k;
            end
            if (b_ack) n_ack++;
        end
        chk("hold_gap", 32'(second_g - first_g), 32'd2);
        chk("hold_grants", 32'(n_gnt), 32'd3);
        chk("hold_acks", 32'(n_ack), 32'(n_gnt));
        b_req = 0;
        cycle();

        // Reset while B is waiting
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h1111_2222;
        b_req = 1; b_we = 1; b_addr = 32'h80; b_wdata = 32'h5555_AAAA;
        cycle(); cycle(); cycle();
        rst = 1;
        cycle();
        chk("rstw_stall", 32'(obs_stall), 32'h1);
        chk("rstw_memwrite", 32'(obs_memwrite), 32'h0);
        rst = 0;
        chk("rstw_b_ack", 32'(b_ack), 32'h0);
        g = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_stall && g < 0) g = k;
            if (b_ack) b_req = 0;
        end
        chk("rstw_grant_cycle", 32'(g), 32'd4);
        a_req = 0; b_req = 0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            a_req   = ($urandom_range(0, 99) < ((n < 1500) ? 85 : 40));
            a_we    = 1'($urandom_range(0, 1));
            a_addr  = rand_addr();
            a_wdata = $urandom;
            if (b_ack || !b_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_req   = 1;
                    b_we    = 1'($urandom_range(0, 1));
                    b_addr  = rand_addr();
                    b_wdata = $urandom;
                end else begin
                    b_req = 0;
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
